// File: rtl/px_us_pkg.sv
// Shared types and sizing helpers for the pixel upsampler.
package px_us_pkg;

  localparam int PX_US_FACTOR = 2;

  typedef enum logic {
    LINE_A = 1'b0,
    LINE_B = 1'b1
  } us_state_t;

  typedef logic us_phase_t;

  function automatic int px_us_cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/px_us_line_buf.sv
// One-line pixel store: synchronous write port, combinational read port.
module px_us_line_buf
  import px_us_pkg::*;
#(
  parameter int DEPTH    = 960,
  parameter int PX_WIDTH = 30,
  parameter int AW       = px_us_cw(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [PX_WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]       rd_addr,
  output logic [PX_WIDTH-1:0] rd_dat
);

  logic [PX_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/px_upsampler.sv
// AXI4-Stream 2x pixel upsampler with bypass; output is a single register slot.
// PX_UPSAMPLER_VERT_EN adds vertical line doubling (line buffer + LINE_B replay).
module px_upsampler
  import px_us_pkg::*;
#(
  parameter int PX_WIDTH    = 30,
  parameter int FRAME_RES_X = 1920,
  parameter int TDATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ups_en_i,
  input  logic [TDATA_WIDTH-1:0] video_i_tdata,
  input  logic                   video_i_tvalid,
  input  logic                   video_i_tlast,
  input  logic                   video_i_tuser,
  output logic                   video_i_tready,
  output logic [TDATA_WIDTH-1:0] video_o_tdata,
  output logic                   video_o_tvalid,
  output logic                   video_o_tlast,
  output logic                   video_o_tuser,
  input  logic                   video_o_tready
);

  localparam int IN_RES_X = FRAME_RES_X / PX_US_FACTOR;
  localparam int XW       = px_us_cw(IN_RES_X + 1);
  localparam logic [XW-1:0] X_MAX = XW'(IN_RES_X);

  us_state_t           state;
  us_phase_t           phase;
  logic [XW-1:0]       x;
  logic                mode;
  logic [PX_WIDTH-1:0] hold_px;
  logic                hold_last;
  logic [PX_WIDTH-1:0] out_px;

  logic                slot_free;
  logic                accept;
  logic                mode_eff;
  logic [XW-1:0]       x_inc;
  logic [PX_WIDTH-1:0] in_px;
  logic                unused_in;

  assign in_px          = video_i_tdata[PX_WIDTH-1:0];
  assign unused_in      = ^video_i_tdata;
  assign slot_free      = !video_o_tvalid || video_o_tready;
  // Bypass never leaves LINE_A/phase 0, so one ready term covers both modes.
  assign video_i_tready = rst_i && slot_free && (state == LINE_A) && (phase == 1'b0);
  assign accept         = video_i_tvalid && video_i_tready;
  assign mode_eff       = (video_i_tuser && (x == '0)) ? ups_en_i : mode;
  // x saturates at IN_RES_X so overlong lines stop writing and clamp the replay length.
  assign x_inc          = (x == X_MAX) ? x : x + 1'b1;
  assign video_o_tdata  = TDATA_WIDTH'(out_px);

`ifdef PX_UPSAMPLER_VERT_EN
  localparam int AW = px_us_cw(IN_RES_X);
  logic [XW-1:0]       line_len;
  logic [PX_WIDTH-1:0] rd_px;
  logic                wr_en;
  logic                last_px;

  assign wr_en   = accept && mode_eff && (x < X_MAX);
  assign last_px = (x == line_len - 1'b1);

  px_us_line_buf #(
    .DEPTH    (IN_RES_X),
    .PX_WIDTH (PX_WIDTH),
    .AW       (AW)
  ) u_line_buf (
    .clk     (clk_i),
    .wr_en   (wr_en),
    .wr_addr (x[AW-1:0]),
    .wr_dat  (in_px),
    .rd_addr (x[AW-1:0]),
    .rd_dat  (rd_px)
  );
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= LINE_A;
      phase          <= 1'b0;
      x              <= '0;
      mode           <= 1'b0;
      hold_px        <= '0;
      hold_last      <= 1'b0;
      out_px         <= '0;
      video_o_tvalid <= 1'b0;
      video_o_tlast  <= 1'b0;
      video_o_tuser  <= 1'b0;
`ifdef PX_UPSAMPLER_VERT_EN
      line_len       <= '0;
`endif
    end else if (slot_free) begin
      if (state == LINE_A && phase == 1'b0) begin
        video_o_tvalid <= accept;
        if (accept) begin
          mode          <= mode_eff;
          out_px        <= in_px;
          video_o_tuser <= video_i_tuser;
          video_o_tlast <= video_i_tlast && !mode_eff;
          hold_px       <= in_px;
          hold_last     <= video_i_tlast;
          if (mode_eff) phase <= 1'b1;
        end
      end else if (state == LINE_A) begin
        video_o_tvalid <= 1'b1;
        out_px         <= hold_px;
        video_o_tuser  <= 1'b0;
        video_o_tlast  <= hold_last;
        phase          <= 1'b0;
        if (hold_last) begin
          x <= '0;
`ifdef PX_UPSAMPLER_VERT_EN
          line_len <= x_inc;
          state    <= LINE_B;
`endif
        end else begin
          x <= x_inc;
        end
      end else begin
`ifdef PX_UPSAMPLER_VERT_EN
        video_o_tvalid <= 1'b1;
        out_px         <= rd_px;
        video_o_tuser  <= 1'b0;
        video_o_tlast  <= phase && last_px;
        phase          <= !phase;
        if (phase && last_px) begin
          x     <= '0;
          state <= LINE_A;
        end else if (phase) begin
          x <= x + 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_px_upsampler.sv
// Randomized directed bench for px_upsampler (FRAME_RES_X=8) with a line-level reference model.
module tb_px_upsampler;

  localparam int FRX = 8;
  localparam int INX = FRX / 2;
  localparam logic [31:0] PXM = 32'h3FFF_FFFF;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        u;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        ups_en_i = 1'b0;
  logic [31:0] vi_dat = '0;
  logic        vi_vld = 1'b0;
  logic        vi_last = 1'b0;
  logic        vi_user = 1'b0;
  logic        vi_rdy;
  logic [31:0] vo_dat;
  logic        vo_vld;
  logic        vo_last;
  logic        vo_user;
  logic        vo_rdy = 1'b1;

  always #5 clk_i = ~clk_i;

  px_upsampler #(
    .PX_WIDTH    (30),
    .FRAME_RES_X (FRX),
    .TDATA_WIDTH (32)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ups_en_i       (ups_en_i),
    .video_i_tdata  (vi_dat),
    .video_i_tvalid (vi_vld),
    .video_i_tlast  (vi_last),
    .video_i_tuser  (vi_user),
    .video_i_tready (vi_rdy),
    .video_o_tdata  (vo_dat),
    .video_o_tvalid (vo_vld),
    .video_o_tlast  (vo_last),
    .video_o_tuser  (vo_user),
    .video_o_tready (vo_rdy)
  );

  int    checks = 0;
  int    errors = 0;
  beat_t got[$];
  beat_t exp_q[$];
  logic  stall_q = 1'b0;
  logic [34:0] saved = '0;
  bit    rnd_on = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output monitor: records every transfer and checks outputs hold while stalled.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) chk("stall_hold", {vo_dat, vo_last, vo_user, vo_vld}, saved);
      if (vo_vld && vo_rdy) got.push_back({vo_dat, vo_last, vo_user});
      stall_q <= vo_vld && !vo_rdy;
      saved   <= {vo_dat, vo_last, vo_user, vo_vld};
    end
  end

  // Expected output of one input line, straight from the up/bypass rules.
  function automatic void model(input logic [31:0] pix[$], input bit fu, input int mid, input bit ups);
    int    n;
    int    m;
    beat_t b;
    n = pix.size();
    for (int i = 0; i < n; i++) begin
      b.d = pix[i] & PXM;
      b.u = (i == 0 && fu) || (i == mid);
      if (!ups) begin
        b.l = (i == n - 1);
        exp_q.push_back(b);
      end else begin
        b.l = 1'b0;
        exp_q.push_back(b);
        b.u = 1'b0;
        b.l = (i == n - 1);
        exp_q.push_back(b);
      end
    end
`ifdef PX_UPSAMPLER_VERT_EN
    if (ups) begin
      m = (n < INX) ? n : INX;
      for (int i = 0; i < m; i++) begin
        b.d = pix[i] & PXM;
        b.u = 1'b0;
        b.l = 1'b0;
        exp_q.push_back(b);
        b.l = (i == m - 1);
        exp_q.push_back(b);
      end
    end
`else
    m = 0;
`endif
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic l, input logic u, input bit ups);
    int n;
    n = 0;
    @(posedge clk_i);
    #1;
    vi_dat  = d;
    vi_last = l;
    vi_user = u;
    vi_vld  = 1'b1;
    @(negedge clk_i);
    while (!vi_rdy && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    chk("in_accept", {63'd0, vi_rdy}, 64'd1);
    if (!vi_rdy) begin
      vi_vld = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1;
    vi_vld = 1'b0;
    @(negedge clk_i);
    chk("first_copy", {vo_vld, vo_dat, vo_last, vo_user}, {1'b1, d & PXM, ups ? 1'b0 : l, u});
  endtask

  task automatic send_line(input int n, input bit ups, input bit fu, input int mid);
    logic [31:0] pix[$];
    for (int i = 0; i < n; i++) pix.push_back($urandom);
    model(pix, fu, mid, ups);
    // Lines that do not start a frame drive the opposite enable: it must be ignored.
    ups_en_i = fu ? ups : !ups;
    for (int i = 0; i < n; i++)
      send_beat(pix[i], i == n - 1, (i == 0 && fu) || (i == mid), ups);
  endtask

  task automatic run_check(input string tag);
    int n;
    n = 0;
    while (got.size() < exp_q.size() && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    repeat (4) @(negedge clk_i);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(tag, 64'(got[i]), 64'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    // Reset state, with input offered and output ready to prove nothing leaks through.
    vi_vld  = 1'b1;
    vi_user = 1'b1;
    vi_dat  = 32'h1234_5678;
    repeat (3) @(negedge clk_i);
    chk("rst_vld", {63'd0, vo_vld}, 64'd0);
    chk("rst_dat", {32'd0, vo_dat}, 64'd0);
    chk("rst_last", {63'd0, vo_last}, 64'd0);
    chk("rst_user", {63'd0, vo_user}, 64'd0);
    chk("rst_rdy", {63'd0, vi_rdy}, 64'd0);
    vi_vld  = 1'b0;
    vi_user = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    send_line(4, 1'b0, 1'b1, -1);
    run_check("bypass");

    send_line(4, 1'b1, 1'b1, -1);
    run_check("ups");

    rnd_on = 1'b1;
    fork
      begin
        send_line(4, 1'b1, 1'b1, -1);
        send_line(4, 1'b1, 1'b0, 2);
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk_i);
          #1;
          vo_rdy = 1'($urandom_range(0, 1));
        end
        vo_rdy = 1'b1;
      end
    join
    run_check("random");

    send_line(1, 1'b1, 1'b1, -1);
    run_check("short");

    send_line(6, 1'b1, 1'b1, -1);
    run_check("long");

    send_line(3, 1'b0, 1'b1, -1);
    run_check("back_bypass");

    // Reset in the middle of an upsampled line (inside the replay when it exists).
    send_line(4, 1'b1, 1'b1, -1);
`ifdef PX_UPSAMPLER_VERT_EN
    n = 0;
    while (got.size() < 10 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("reach_line_b", {63'd0, got.size() >= 10}, 64'd1);
`else
    n = 0;
`endif
    #2;
    rst_i = 1'b0;
    #1;
    chk("mid_rst_vld", {63'd0, vo_vld}, 64'd0);
    chk("mid_rst_dat", {32'd0, vo_dat}, 64'd0);
    chk("mid_rst_last", {63'd0, vo_last}, 64'd0);
    chk("mid_rst_user", {63'd0, vo_user}, 64'd0);
    chk("mid_rst_rdy", {63'd0, vi_rdy}, 64'd0);
    repeat (2) @(negedge clk_i);
    got.delete();
    exp_q.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    send_line(2, 1'b0, 1'b0, -1);
    send_line(4, 1'b1, 1'b1, -1);
    run_check("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/px_upsampler.md
Name: px_upsampler

Overview:
- Restores resolution after pixel subsampling on the AXI4-Stream video path.
- Sits downstream of decimated processing and before output or display stages.
- In upsample mode:
  - every input pixel is emitted twice (horizontal 2x);
  - every input line is emitted twice (vertical 2x), with the repeat line replayed from an internal line buffer.
- In bypass mode the stream passes through unchanged with one register stage.

Parameters:
- PX_WIDTH, 30: pixel bits; these are the low bits of tdata.
- FRAME_RES_X, 1920: output line length in upsample mode. Input line length is IN_RES_X = FRAME_RES_X/2.
- TDATA_WIDTH, 32: stream data width; must be >= PX_WIDTH.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- ups_en_i  in  1  1 = 2x upsample, 0 = bypass; sampled at frame start
- video_i_tdata  in  TDATA_WIDTH  input pixel
- video_i_tvalid  in  1  input valid
- video_i_tlast  in  1  last pixel of input line
- video_i_tuser  in  1  first pixel of frame
- video_i_tready  out  1  input ready
- video_o_tdata  out  TDATA_WIDTH  output pixel; bits above PX_WIDTH are 0
- video_o_tvalid  out  1  output valid
- video_o_tlast  out  1  last pixel of output line
- video_o_tuser  out  1  first pixel of output frame
- video_o_tready  in  1  output ready

Behaviour:
- Reset (rst_i=0, asynchronous):
  - all video_o_* = 0; video_i_tready = 0;
  - state = LINE_A, phase = 0, x = 0, line_len = 0, mode = bypass.
- Output is a single register slot.
  - The slot is free when !video_o_tvalid || video_o_tready.
  - Outputs hold stable while video_o_tvalid && !video_o_tready.
- Mode latch: ups_en_i is captured when an input beat with tuser=1 is accepted while x==0. The new mode applies to that beat.
- Bypass:
  - video_i_tready = slot free.
  - An accepted beat appears at the output the next cycle with tdata, tlast and tuser copied.
- Upsample FSM states: LINE_A (live line), LINE_B (replay).
- LINE_A, phase 0:
  - video_i_tready = slot free.
  - On accept: hold pixel; write buffer[x] if x < IN_RES_X; load output with tuser = input tuser, tlast = 0; go to phase 1.
- LINE_A, phase 1:
  - video_i_tready = 0.
  - When the slot is free: emit the held pixel again with tuser = 0 and tlast = held input tlast.
  - If held tlast: line_len = min(x+1, IN_RES_X), x = 0, go to LINE_B. Otherwise x++, go to phase 0.
- LINE_B:
  - video_i_tready = 0.
  - Emit buffer[x] twice (phase 0, then phase 1) with tuser = 0.
  - tlast = 1 on phase 1 when x == line_len-1; then x = 0 and go to LINE_A.
- Latency and throughput:
  - First output follows acceptance by 1 cycle.
  - Input sustains 1 pixel per 2 cycles in LINE_A and stalls for the whole of LINE_B.
  - Output sustains 1 pixel per cycle under continuous ready.
- Boundary cases:
  - Input line longer than IN_RES_X: extra pixels are emitted in LINE_A but not stored. Replay length saturates at IN_RES_X.
  - tlast on the first pixel: line_len = 1, so each output line is 2 pixels.
  - tuser in mid-line: passed through on the first copy only; does not reset the FSM.
  - Backpressure in any state: the FSM does not advance.

Optional Feature:
- Macro: PX_UPSAMPLER_VERT_EN
- Defined: vertical line duplication as above, including the line buffer and LINE_B.
- Undefined: no line buffer and no LINE_B; horizontal 2x only. After the phase-1 tlast beat the FSM returns to LINE_A, phase 0.

Decomposition:
- Package px_us_pkg:
  - state enum (LINE_A, LINE_B);
  - phase type;
  - function clog2-based X counter width;
  - PX_US_FACTOR = 2.
- Sub-module px_us_line_buf: IN_RES_X x PX_WIDTH memory with one write port and a combinational read port. Instantiated only under PX_UPSAMPLER_VERT_EN.

Test Plan (FRAME_RES_X=8, so IN_RES_X=4):
- Bypass with ups_en_i=0: input frame A,B,C,D (tuser on A, tlast on D) → identical output, each beat 1 cycle later.
- Upsample with ups_en_i=1, ready held high: line P0..P3 → output line P0,P0,P1,P1,P2,P2,P3,P3 (tuser on the first P0, tlast on the last P3), then the same 8 pixels again with tuser=0 and tlast on the last.
- Random video_o_tready (~50%) on a 2-line frame → 32 output pixels in the correct order, and no output change while stalled.
- Short line with tlast on the first pixel (X) → X,X with tlast on the second X, then X,X replayed with tlast.
- Long line of 6 pixels → 12 output pixels, then a 4-pixel replay (8 outputs) of the first 4 pixels.
- Reset asserted during LINE_B → outputs 0 immediately. After release, the next frame starts cleanly in bypass until a tuser beat latches the mode. Without PX_UPSAMPLER_VERT_EN there is no replay line.
